if_id_queue: RTL

- Decoupling instruction queue between the instruction-fetch stage and the decode stage.
- Captures the fetched PC/instruction pair every cycle the fetch stage is not frozen, and buffers up to DEPTH entries.
- Presents entries in order to decode with a valid/ready handshake.
- Drives the fetch stage's freeze input when full; discards all wrong-path entries on a taken branch.

---
 rtl/if_id_queue.sv | 138 +++++++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// if_id_queue
// Decoupling instruction queue between instruction fetch and decode.
// Each cycle that fetch is not frozen and no branch is taken, the
// {PCIn, instructionIn} pair is captured. Up to DEPTH entries are buffered
// and presented in order to decode through a valid/idReady handshake.
// freeze stalls fetch while the queue is full. brTaken discards every
// buffered entry together with the word presented in that cycle.
//
// Parameters:
//   DEPTH          number of entries (power of two, >= 2)
//   WIDTH          width of PC and instruction words
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   PCIn           PC from fetch
//   instructionIn  fetched instruction word
//   brTaken        taken-branch flush
//   idReady        decode accepts the head entry this cycle
//   freeze         to fetch: hold PC (queue full)
//   PCOut          PC of the head entry (0 when not valid)
//   instructionOut instruction of the head entry (0 when not valid)
//   valid          head entry valid
//   count          occupancy
//
// Optional feature (macro IFQ_BYPASS_EN):
//   With the macro defined, an empty queue forwards the input pair
//   combinationally to decode when decode is ready and no branch is taken.
//   The forwarded pair is not stored. With the macro undefined (the default
//   build), there is no input-to-output path.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         PCIn,
  input  logic [WIDTH-1:0]         instructionIn,
  input  logic                     brTaken,
  input  logic                     idReady,
  output logic                     freeze,
  output logic [WIDTH-1:0]         PCOut,
  output logic [WIDTH-1:0]         instructionOut,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [AW-1:0]    PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [WIDTH-1:0] WORD_ZERO = WIDTH'(0);

  logic [WIDTH-1:0] pc_mem_r    [DEPTH];
  logic [WIDTH-1:0] instr_mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;

  logic             full_s;
  logic             stored_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;

  // Handshake decode: occupancy is taken from count alone, never from pointer compare.
  always_comb begin
    full_s   = (count_r == CNT_FULL);
    stored_s = (count_r != CNT_ZERO);
`ifdef IFQ_BYPASS_EN
    // The forwarded word goes straight to decode, so it is neither pushed nor popped.
    bypass_s = ~rst & ~stored_s & ~brTaken & idReady;
`else
    bypass_s = 1'b0;
`endif
    // freeze relies only on registered state. A pop in a full cycle does not open a slot
    // for a push in that same cycle.
    push_s   = ~full_s & ~brTaken & ~bypass_s;
    pop_s    = stored_s & idReady & ~brTaken;
  end

  // Pointer and occupancy state. Reset has priority over flush, and flush has priority over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (brTaken) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      // DEPTH is a power of two, so the natural pointer overflow gives the DEPTH-1 -> 0 wrap.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage. It has no reset because the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= PCIn;
      instr_mem_r[wr_ptr_r] <= instructionIn;
    end
  end

  // Output view. An empty queue presents a NOP (all zeros) unless the input is bypassed.
  always_comb begin
    freeze = full_s;
    count  = count_r;
    if (bypass_s) begin
      valid          = 1'b1;
      PCOut          = PCIn;
      instructionOut = instructionIn;
    end else if (stored_s) begin
      valid          = 1'b1;
      PCOut          = pc_mem_r[rd_ptr_r];
      instructionOut = instr_mem_r[rd_ptr_r];
    end else begin
      valid          = 1'b0;
      PCOut          = WORD_ZERO;
      instructionOut = WORD_ZERO;
    end
  end

endmodule
